// File: rtl/bus_fabric_if.sv
// Bus bundle between the core, the fabric and the slave devices.
// Signals:
//   m_address, m_wdata, m_nread, m_nwrite : core request (nread/nwrite active-low)
//   m_rdata, m_ready                      : read data and one-cycle completion pulse to the core
//   s_address, s_wdata                    : latched address/data shared by all slaves
//   s_nread, s_nwrite                     : per-slave active-low strobes
//   s_rdata                               : slave read data, slave i at [i*DATA_W +: DATA_W]
// Modports:
//   master : the environment (core plus slave devices) driving the fabric
//   slave  : the fabric itself
interface bus_fabric_if #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_SLAVES = 3
);
    logic [ADDR_W-1:0]            m_address;
    logic [DATA_W-1:0]            m_wdata;
    logic                         m_nread;
    logic                         m_nwrite;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_ready;
    logic [ADDR_W-1:0]            s_address;
    logic [DATA_W-1:0]            s_wdata;
    logic [NUM_SLAVES-1:0]        s_nread;
    logic [NUM_SLAVES-1:0]        s_nwrite;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;

    modport master (
        output m_address, m_wdata, m_nread, m_nwrite, s_rdata,
        input  m_rdata, m_ready, s_address, s_wdata, s_nread, s_nwrite
    );

    modport slave (
        input  m_address, m_wdata, m_nread, m_nwrite, s_rdata,
        output m_rdata, m_ready, s_address, s_wdata, s_nread, s_nwrite
    );
endinterface

// File: rtl/bus_fabric.sv
// Single-clock interconnect from one core bus to NUM_SLAVES slave devices.
// The top SEL_W address bits pick the slave; WAIT_CYCLES wait states precede a
// one-cycle slave strobe, and the core sees a one-cycle m_ready pulse on completion.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : bus_fabric_if.slave (core request/response and slave strobes/data)
// Optional (macro BUS_FABRIC_ERRLOG_EN):
//   err_count   : saturating count of unmapped accesses and both-low request episodes
//   err_address : address of the most recent such error
module bus_fabric #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_SLAVES  = 3,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic          clock,
    input logic          reset,
    bus_fabric_if.slave  bus
`ifdef BUS_FABRIC_ERRLOG_EN
    ,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] err_address
`endif
);

    localparam int unsigned SEL_W   = $clog2(NUM_SLAVES);
    localparam logic [3:0]  CntLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {StIdle, StWait, StAccess, StDone, StRelease} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  is_read_q, is_read_d;
    logic [SEL_W-1:0]      idx_q, idx_d;
    logic [NUM_SLAVES-1:0] nread_q, nread_d;
    logic [NUM_SLAVES-1:0] nwrite_q, nwrite_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  ready_q, ready_d;

`ifdef BUS_FABRIC_ERRLOG_EN
    logic [7:0]        err_count_q, err_count_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              err_armed_q, err_armed_d;  // set while a both-low episode is logged
    logic              mapped;
`endif

    logic                  req_rd, req_wr, req_both;
    logic [SEL_W-1:0]      idx_in;
    logic [SEL_W-1:0]      launch_idx;
    logic                  launch_rd;
    logic [NUM_SLAVES-1:0] launch_onehot;
    logic [DATA_W-1:0]     sel_rdata;

    always_comb begin
        req_rd   = !bus.m_nread && bus.m_nwrite;
        req_wr   = bus.m_nread && !bus.m_nwrite;
        req_both = !bus.m_nread && !bus.m_nwrite;
        idx_in   = bus.m_address[ADDR_W-1 -: SEL_W];

        // Strobes launch from the capture cycle when there are no wait states,
        // otherwise from the latched request at the end of WAIT.
        launch_idx = (state_q == StIdle) ? idx_in : idx_q;
        launch_rd  = (state_q == StIdle) ? req_rd : is_read_q;

        // An unmapped index matches no slave, leaving all strobes high.
        launch_onehot = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (launch_idx == SEL_W'(i)) begin
                launch_onehot[i] = 1'b1;
            end
        end

        // Unmapped reads return all ones.
        sel_rdata = '1;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        idx_d     = idx_q;
        nread_d   = nread_q;
        nwrite_d  = nwrite_q;
        rdata_d   = rdata_q;
        ready_d   = ready_q;
`ifdef BUS_FABRIC_ERRLOG_EN
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        err_armed_d = err_armed_q;
        mapped      = {1'b0, idx_q} < (SEL_W + 1)'(NUM_SLAVES);
`endif

        unique case (state_q)
            StIdle: begin
                if (req_rd || req_wr) begin
                    addr_d    = bus.m_address;
                    wdata_d   = bus.m_wdata;
                    is_read_d = req_rd;
                    idx_d     = idx_in;
                    if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end else begin
                        state_d  = StAccess;
                        nread_d  = launch_rd ? ~launch_onehot : '1;
                        nwrite_d = launch_rd ? '1 : ~launch_onehot;
                    end
                end
`ifdef BUS_FABRIC_ERRLOG_EN
                if (req_both && !err_armed_q) begin
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    err_addr_d  = bus.m_address;
                    err_armed_d = 1'b1;
                end
`endif
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d  = StAccess;
                    nread_d  = launch_rd ? ~launch_onehot : '1;
                    nwrite_d = launch_rd ? '1 : ~launch_onehot;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAccess: begin
                nread_d  = '1;
                nwrite_d = '1;
                ready_d  = 1'b1;
                state_d  = StDone;
                if (is_read_q) begin
                    rdata_d = sel_rdata;
                end
`ifdef BUS_FABRIC_ERRLOG_EN
                if (!mapped) begin
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    err_addr_d = addr_q;
                end
`endif
            end
            StDone: begin
                ready_d = 1'b0;
                state_d = StRelease;
            end
            StRelease: begin
                // A request still held low here has already been served.
                if (bus.m_nread && bus.m_nwrite) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef BUS_FABRIC_ERRLOG_EN
        if (!req_both) begin
            err_armed_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            idx_q     <= '0;
            nread_q   <= '1;
            nwrite_q  <= '1;
            rdata_q   <= '1;
            ready_q   <= 1'b0;
`ifdef BUS_FABRIC_ERRLOG_EN
            err_count_q <= 8'd0;
            err_addr_q  <= '0;
            err_armed_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            idx_q     <= idx_d;
            nread_q   <= nread_d;
            nwrite_q  <= nwrite_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
`ifdef BUS_FABRIC_ERRLOG_EN
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            err_armed_q <= err_armed_d;
`endif
        end
    end

    assign bus.m_rdata   = rdata_q;
    assign bus.m_ready   = ready_q;
    assign bus.s_address = addr_q;
    assign bus.s_wdata   = wdata_q;
    assign bus.s_nread   = nread_q;
    assign bus.s_nwrite  = nwrite_q;

`ifdef BUS_FABRIC_ERRLOG_EN
    assign err_count   = err_count_q;
    assign err_address = err_addr_q;
`endif

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised successor to the single-master/single-slave core-to-memory interconnect.
- Connects the core's bus (address, data, active-low nread/nwrite) to NUM_SLAVES slaves, selected by the top address bits.
- Inserts a programmable number of wait states, which replaces the fixed half-rate memory clock.
- Returns a one-cycle ready pulse to the master, so all devices run on the single system clock.

Parameters:
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
NUM_SLAVES, 3, number of slave ports (2..8); SEL_W = $clog2(NUM_SLAVES) top address bits select the slave
WAIT_CYCLES, 1, wait-state clocks inserted before the slave strobe (0..15)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
m_address  input  ADDR_W  master address
m_wdata  input  DATA_W  master write data
m_nread  input  1  master read request, active-low
m_nwrite  input  1  master write request, active-low
m_rdata  output  DATA_W  read data returned to master
m_ready  output  1  transfer-complete pulse, high for exactly one cycle
s_address  output  ADDR_W  latched address, shared by all slaves
s_wdata  output  DATA_W  latched write data, shared by all slaves
s_nread  output  NUM_SLAVES  per-slave read strobe, active-low
s_nwrite  output  NUM_SLAVES  per-slave write strobe, active-low
s_rdata  input  NUM_SLAVES*DATA_W  slave read data; slave i occupies bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE, m_ready 0, m_rdata all ones
  - s_nread and s_nwrite all ones, s_address 0, s_wdata 0, wait counter 0
  - Reset asserted mid-transfer drops any active strobe immediately; the transfer is abandoned and m_ready is never pulsed.
- Slave index = m_address[ADDR_W-1 -: SEL_W]. An index >= NUM_SLAVES is unmapped.
- FSM states: IDLE, WAIT, ACCESS, DONE, RELEASE.
- IDLE:
  - Exactly one of m_nread/m_nwrite low at an edge (E0): latch address, wdata, direction and index.
  - Then go to WAIT if WAIT_CYCLES>0, else go to ACCESS.
  - Both low: protocol error, stay in IDLE, no slave activity.
- WAIT: counter loads WAIT_CYCLES-1 and decrements each clock; at 0, go to ACCESS. Occupies exactly WAIT_CYCLES cycles.
- ACCESS (1 cycle):
  - Only the selected slave's strobe is low; all others stay high.
  - On a read, s_rdata of that slave is registered into m_rdata at the end of the cycle.
  - Unmapped index: no strobe; a read loads m_rdata with all ones; a write is dropped.
- DONE (1 cycle): m_ready=1. m_rdata holds its value until the next read completes; writes do not alter it.
- RELEASE: wait until m_nread=m_nwrite=1, then go to IDLE. A request held low after ready is never re-issued.
- Latency: strobe low in the cycle after edge E0+WAIT_CYCLES; m_ready high in the cycle after edge E0+WAIT_CYCLES+1.
- Minimum request-to-request spacing is WAIT_CYCLES+4 cycles.
- s_address and s_wdata change only on the IDLE capture edge and are stable through ACCESS.
- Master inputs changing after E0 are ignored until the transfer returns to IDLE.

Optional Feature:
- Macro BUS_FABRIC_ERRLOG_EN.
- Defined:
  - Adds output err_count[7:0] (saturates at 255) and err_address[ADDR_W-1:0].
  - Both are reset to 0.
  - Each unmapped access (at ACCESS) increments err_count and captures the address.
  - Each both-low request in IDLE increments err_count once per assertion episode (counted again only after one of nread/nwrite rises) and captures m_address.
- Undefined: neither port nor any logic exists. Unmapped and protocol-error handling is otherwise identical.

Test Plan:
- Defaults. Write 0x5A to 0x4010 → s_nwrite=3'b101 for one cycle, 2 cycles after the request edge, with s_address=0x4010 and s_wdata=0x5A; m_ready pulses one cycle later; m_rdata unchanged (0xFF after reset).
- Read 0x8002, slave2 drives 0x3C → s_nread=3'b011 for one cycle; m_rdata=0x3C with m_ready; 0x3C persists after slave2 changes its data.
- Read 0xC123 (index 3, unmapped) → no strobe asserted; m_rdata=0xFF; m_ready pulses; err_count=1, err_address=0xC123 when BUS_FABRIC_ERRLOG_EN is defined.
- Hold m_nread low for 10 cycles on 0x0001 → exactly one s_nread[0] pulse and one m_ready pulse; the next read is accepted only after m_nread rises.
- m_nread and m_nwrite both low → no strobes and no m_ready; err_count increments once.
- WAIT_CYCLES=3: assert reset in the 2nd WAIT cycle → all strobes stay high and no m_ready; after reset, a read of 0x0000 completes normally with ready 5 cycles after the request edge.
